// File: rtl/t03_dpu_write_sched.sv
// ---------------------------------------------------------------------------
// t03_dpu_write_sched
//
// Frame-synchronous write scheduler. It sits between the CPU MMIO store path
// and the display-side game-state register block. CPU stores to the status
// word and the position word are captured in two coalescing shadow slots.
// Pending slots are replayed onto the register block bus only at the rising
// edge of vblank, so sprite state never changes mid-frame.
//
// Ports:
//   clk, nrst      system clock, asynchronous active-low reset
//   cpu_wr_valid   CPU store request
//   cpu_wr_addr    CPU store address (32)
//   cpu_wr_data    CPU store data (32)
//   cpu_wr_ready   high when a store can be accepted (IDLE only)
//   vblank         vertical-blank level, synchronous to clk
//   dpu_addr       register block address bus (IDLE_ADDR when not replaying)
//   dpu_data       register block data bus (0 when not replaying)
//   commit_done    one-cycle pulse after a replay completes
//   ovw_cnt        saturating count of coalesced overwrites
//
// Optional feature macro: T03_DPU_SCHED_OVW_CNT_EN
//   defined   -> ovw_cnt counts stores that land on an already-pending slot
//   undefined -> counter logic is absent and ovw_cnt is tied to 8'h00
// ---------------------------------------------------------------------------
module t03_dpu_write_sched #(
  parameter logic [31:0] STAT_ADDR = 32'hFF00_0004,
  parameter logic [31:0] POS_ADDR  = 32'hFF00_0008,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cpu_wr_valid,
  input  logic [31:0] cpu_wr_addr,
  input  logic [31:0] cpu_wr_data,
  output logic        cpu_wr_ready,
  input  logic        vblank,
  output logic [31:0] dpu_addr,
  output logic [31:0] dpu_data,
  output logic        commit_done,
  output logic [7:0]  ovw_cnt
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE_STAT = 2'd1,
    ISSUE_POS  = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        stat_pend_q, stat_pend_d;
  logic        pos_pend_q, pos_pend_d;
  logic [31:0] stat_sh_q, stat_sh_d;
  logic [31:0] pos_sh_q, pos_sh_d;
  logic        vblank_q;
  logic [31:0] dpu_addr_q, dpu_addr_d;
  logic [31:0] dpu_data_q, dpu_data_d;
  logic        commit_done_q, commit_done_d;

  logic wr_acc, wr_stat, wr_pos, vb_rise;

  // Stores are only taken while idle; the CPU stalls during a replay.
  assign cpu_wr_ready = (state_q == IDLE);
  assign wr_acc       = cpu_wr_valid && cpu_wr_ready;
  assign wr_stat      = wr_acc && (cpu_wr_addr == STAT_ADDR);
  assign wr_pos       = wr_acc && (cpu_wr_addr == POS_ADDR);
  assign vb_rise      = vblank && !vblank_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d       = state_q;
    stat_pend_d   = stat_pend_q;
    pos_pend_d    = pos_pend_q;
    stat_sh_d     = stat_sh_q;
    pos_sh_d      = pos_sh_q;
    dpu_addr_d    = IDLE_ADDR;
    dpu_data_d    = 32'h0;
    commit_done_d = 1'b0;

    // Capture / coalesce: a newer store simply overwrites the shadow.
    if (wr_stat) begin
      stat_sh_d   = cpu_wr_data;
      stat_pend_d = 1'b1;
    end
    if (wr_pos) begin
      pos_sh_d   = cpu_wr_data;
      pos_pend_d = 1'b1;
    end

    // Bus outputs are registered, so each state sets up the values that the
    // next state presents. The IDLE decision uses the *_d slot values so a
    // store accepted alongside vb_rise joins this replay.
    unique case (state_q)
      IDLE: begin
        if (vb_rise && stat_pend_d) begin
          state_d     = ISSUE_STAT;
          dpu_addr_d  = STAT_ADDR;
          dpu_data_d  = stat_sh_d;
          stat_pend_d = 1'b0;
        end else if (vb_rise && pos_pend_d) begin
          state_d    = ISSUE_POS;
          dpu_addr_d = POS_ADDR;
          dpu_data_d = pos_sh_d;
          pos_pend_d = 1'b0;
        end
      end
      ISSUE_STAT: begin
        if (pos_pend_q) begin
          state_d    = ISSUE_POS;
          dpu_addr_d = POS_ADDR;
          dpu_data_d = pos_sh_q;
          pos_pend_d = 1'b0;
        end else begin
          state_d       = DONE;
          commit_done_d = 1'b1;
        end
      end
      ISSUE_POS: begin
        state_d       = DONE;
        commit_done_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: the shadow slots are plain registers (not a memory array), so
      // they are reset along with everything else.
      state_q       <= IDLE;
      stat_pend_q   <= 1'b0;
      pos_pend_q    <= 1'b0;
      stat_sh_q     <= 32'h0;
      pos_sh_q      <= 32'h0;
      // Starting high hides a vblank that is already asserted out of reset.
      vblank_q      <= 1'b1;
      dpu_addr_q    <= IDLE_ADDR;
      dpu_data_q    <= 32'h0;
      commit_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      stat_pend_q   <= stat_pend_d;
      pos_pend_q    <= pos_pend_d;
      stat_sh_q     <= stat_sh_d;
      pos_sh_q      <= pos_sh_d;
      vblank_q      <= vblank;
      dpu_addr_q    <= dpu_addr_d;
      dpu_data_q    <= dpu_data_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign dpu_addr    = dpu_addr_q;
  assign dpu_data    = dpu_data_q;
  assign commit_done = commit_done_q;

`ifdef T03_DPU_SCHED_OVW_CNT_EN
  logic [7:0] ovw_cnt_q, ovw_cnt_d;

  // A store hitting a slot that still holds an unreplayed value means an
  // intermediate frame update was dropped.
  always_comb begin
    ovw_cnt_d = ovw_cnt_q;
    if (((wr_stat && stat_pend_q) || (wr_pos && pos_pend_q)) &&
        (ovw_cnt_q != 8'hFF)) begin
      ovw_cnt_d = ovw_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovw_cnt_q <= 8'h00;
    end else begin
      ovw_cnt_q <= ovw_cnt_d;
    end
  end

  assign ovw_cnt = ovw_cnt_q;
`else
  assign ovw_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_t03_dpu_write_sched.sv
// ---------------------------------------------------------------------------
// tb_t03_dpu_write_sched
//
// Self-checking bench for t03_dpu_write_sched. The stimulus side keeps a small
// model of the two shadow slots; on each vblank rise it pushes the expected
// bus writes into a scoreboard queue. A negedge monitor pops and compares
// every non-idle bus cycle and counts commit_done pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_t03_dpu_write_sched;

  localparam logic [31:0] STAT_ADDR = 32'hFF00_0004;
  localparam logic [31:0] POS_ADDR  = 32'hFF00_0008;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;

  logic        clk;
  logic        nrst;
  logic        cpu_wr_valid;
  logic [31:0] cpu_wr_addr;
  logic [31:0] cpu_wr_data;
  logic        cpu_wr_ready;
  logic        vblank;
  logic [31:0] dpu_addr;
  logic [31:0] dpu_data;
  logic        commit_done;
  logic [7:0]  ovw_cnt;

  t03_dpu_write_sched dut (
    .clk          (clk),
    .nrst         (nrst),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ready (cpu_wr_ready),
    .vblank       (vblank),
    .dpu_addr     (dpu_addr),
    .dpu_data     (dpu_data),
    .commit_done  (commit_done),
    .ovw_cnt      (ovw_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } bus_wr_t;

  bus_wr_t     exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          commits_seen = 0;
  int          exp_commits  = 0;
  logic        last_issue   = 1'b0;

  // Reference model of the shadow slots.
  logic [31:0] m_stat = 32'h0, m_pos = 32'h0;
  logic        m_stat_pend = 1'b0, m_pos_pend = 1'b0;
  int          m_ovw = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_store(input logic [31:0] a, input logic [31:0] d);
    if (a == STAT_ADDR) begin
      if (m_stat_pend && m_ovw < 255) m_ovw++;
      m_stat = d;
      m_stat_pend = 1'b1;
    end else if (a == POS_ADDR) begin
      if (m_pos_pend && m_ovw < 255) m_ovw++;
      m_pos = d;
      m_pos_pend = 1'b1;
    end
  endtask

  task automatic model_vb();
    if (m_stat_pend) exp_q.push_back('{addr: STAT_ADDR, data: m_stat});
    if (m_pos_pend)  exp_q.push_back('{addr: POS_ADDR,  data: m_pos});
    if (m_stat_pend || m_pos_pend) exp_commits++;
    m_stat_pend = 1'b0;
    m_pos_pend  = 1'b0;
  endtask

  // Reset discards everything in flight: no further writes, no commit.
  task automatic model_reset();
    exp_q.delete();
    m_stat_pend = 1'b0;
    m_pos_pend  = 1'b0;
    m_ovw       = 0;
    exp_commits = commits_seen;
  endtask

  function automatic logic [7:0] exp_ovw();
`ifdef T03_DPU_SCHED_OVW_CNT_EN
    return 8'(m_ovw);
`else
    return 8'h00;
`endif
  endfunction

  // Monitor: every non-idle bus cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!nrst) begin
      last_issue <= 1'b0;
    end else if (dpu_addr != IDLE_ADDR || dpu_data != 32'h0) begin
      if (exp_q.size() == 0) begin
        check("spurious_addr", dpu_addr, IDLE_ADDR);
        check("spurious_data", dpu_data, 32'h0);
      end else begin
        bus_wr_t e;
        e = exp_q.pop_front();
        check("bus_addr", dpu_addr, e.addr);
        check("bus_data", dpu_data, e.data);
      end
      last_issue <= 1'b1;
    end else begin
      if (commit_done) begin
        commits_seen++;
        check("commit_after_issue", 32'(last_issue), 32'd1);
        check("commit_q_empty", exp_q.size(), 32'd0);
      end
      last_issue <= 1'b0;
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    bit ok;
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = a;
    cpu_wr_data  = d;
    stalls = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_wr_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) check("store_timeout", 32'(stalls), 32'd0);
    @(posedge clk);
    if (ok) model_store(a, d);
    #1;
    cpu_wr_valid = 1'b0;
  endtask

  task automatic end_scenario(input string tag);
    check({tag, "_commits"}, commits_seen, exp_commits);
    check({tag, "_q_empty"}, exp_q.size(), 32'd0);
    check({tag, "_ovw"}, 32'(ovw_cnt), 32'(exp_ovw()));
    check({tag, "_ready"}, 32'(cpu_wr_ready), 32'd1);
  endtask

  // Raise vblank from idle, let the replay run out, then drop it.
  task automatic pulse_vb(input string tag);
    vblank = 1'b1;
    model_vb();
    repeat (6) @(posedge clk);
    #1 vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    end_scenario(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    nrst = 1'b0;
    cpu_wr_valid = 1'b0;
    cpu_wr_addr = 32'h0;
    cpu_wr_data = 32'h0;
    vblank = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", dpu_addr, IDLE_ADDR);
    check("rst_data", dpu_data, 32'h0);
    check("rst_ready", 32'(cpu_wr_ready), 32'd1);
    check("rst_commit", 32'(commit_done), 32'd0);
    check("rst_ovw", 32'(ovw_cnt), 32'd0);
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single status store with cycle-exact timing.
    do_store(STAT_ADDR, 32'h51A3_0002, st);
    check("s1_stall", st, 32'd0);
    vblank = 1'b1;
    model_vb();
    @(posedge clk);
    @(negedge clk);
    check("s1_issue_addr", dpu_addr, STAT_ADDR);
    check("s1_issue_data", dpu_data, 32'h51A3_0002);
    check("s1_issue_commit", 32'(commit_done), 32'd0);
    check("s1_issue_ready", 32'(cpu_wr_ready), 32'd0);
    @(negedge clk);
    check("s1_done_addr", dpu_addr, IDLE_ADDR);
    check("s1_done_commit", 32'(commit_done), 32'd1);
    @(negedge clk);
    check("s1_idle_commit", 32'(commit_done), 32'd0);
    check("s1_idle_ready", 32'(cpu_wr_ready), 32'd1);
    @(posedge clk);
    #1 vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    end_scenario("s1");

    // 2: both slots, status first, then an empty vblank.
    do_store(STAT_ADDR, 32'h1111_0000, st);
    do_store(POS_ADDR,  32'h1020_3040, st);
    pulse_vb("s2");
    pulse_vb("s2_empty");

    // 3: three position stores coalesce into one replay.
    do_store(POS_ADDR, 32'h0101_0101, st);
    do_store(POS_ADDR, 32'h0202_0202, st);
    do_store(POS_ADDR, 32'h0303_0303, st);
    pulse_vb("s3");

    // 4: unrelated addresses are accepted and ignored.
    do_store(32'hFF00_000C, 32'hDEAD_BEEF, st);
    check("s4_stall_c", st, 32'd0);
    do_store(32'h0000_0000, 32'h1234_5678, st);
    check("s4_stall_0", st, 32'd0);
    pulse_vb("s4");

    // 5: position store held during ISSUE_STAT stalls, then waits a frame.
    do_store(STAT_ADDR, 32'hA5A5_0005, st);
    vblank = 1'b1;
    model_vb();
    @(posedge clk);
    #1;
    do_store(POS_ADDR, 32'h0505_0505, st);
    check("s5_stall", st, 32'd2);
    repeat (4) @(posedge clk);
    #1 vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    end_scenario("s5_cur");
    pulse_vb("s5_next");

    // 6: store accepted in the same cycle as the vblank rise joins the replay.
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = STAT_ADDR;
    cpu_wr_data  = 32'hCAFE_0006;
    vblank       = 1'b1;
    @(negedge clk);
    check("s6_ready", 32'(cpu_wr_ready), 32'd1);
    @(posedge clk);
    model_store(STAT_ADDR, 32'hCAFE_0006);
    model_vb();
    #1 cpu_wr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    end_scenario("s6");

    // 7: reset during ISSUE_STAT with position pending; vblank stays high.
    do_store(STAT_ADDR, 32'h7777_0007, st);
    do_store(POS_ADDR,  32'h7070_7070, st);
    vblank = 1'b1;
    model_vb();
    @(posedge clk);
    #1 nrst = 1'b0;
    model_reset();
    #1;
    check("s7_rst_addr", dpu_addr, IDLE_ADDR);
    check("s7_rst_data", dpu_data, 32'h0);
    check("s7_rst_ready", 32'(cpu_wr_ready), 32'd1);
    check("s7_rst_commit", 32'(commit_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (4) @(posedge clk);
    #1 vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    end_scenario("s7_rel");
    pulse_vb("s7_vb");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
